// File: rtl/gcd_stein_hs.sv
// Binary (Stein) GCD engine with valid/ready handshakes on operand and result sides.
// One reduction step per clock; reports the number of CALC cycles with each result.
module gcd_stein_hs #(
    parameter  int WIDTH  = 16,
    localparam int ITER_W = $clog2(2*WIDTH+2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  gcd,
    output logic [ITER_W-1:0] iter
);

    localparam int K_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    u_q, u_d;
    logic [WIDTH-1:0]    v_q, v_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [WIDTH-1:0]    gcd_q, gcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                out_valid_q, out_valid_d;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign gcd       = gcd_q;
    assign iter      = iter_q;

    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        v_d         = v_q;
        k_d         = k_q;
        gcd_d       = gcd_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    u_d    = a;
                    v_d    = b;
                    k_d    = '0;
                    iter_d = '0;
                    // A zero operand short-circuits: gcd(x,0) = x, gcd(0,0) = 0.
                    if (a == '0 || b == '0) begin
                        gcd_d       = a | b;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                iter_d = iter_q + ITER_W'(1);
                if (u_q == v_q) begin
                    gcd_d       = u_q << k_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (!u_q[0] && !v_q[0]) begin
                    u_d = u_q >> 1;
                    v_d = v_q >> 1;
                    k_d = k_q + K_W'(1);
                end else if (!u_q[0]) begin
                    u_d = u_q >> 1;
                end else if (!v_q[0]) begin
                    v_d = v_q >> 1;
                end else if (u_q > v_q) begin
                    // Both odd: the difference is even, so halving loses nothing.
                    u_d = (u_q - v_q) >> 1;
                end else begin
                    v_d = (v_q - u_q) >> 1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            u_q         <= '0;
            v_q         <= '0;
            k_q         <= '0;
            gcd_q       <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            v_q         <= v_d;
            k_q         <= k_d;
            gcd_q       <= gcd_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
